// File: rtl/pc_seq.sv
// Instruction-fetch program counter: increment, absolute/relative branches,
// call/return stack with fault flag, fetch stall and sticky halt address.
module pc_seq #(
  parameter int          W          = 16,
  parameter int          OW         = 8,
  parameter int          DEPTH      = 4,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned HALT_ADDR  = 143
) (
  input  logic                         CLK,
  input  logic                         Init,
  input  logic                         Stall,
  input  logic                         B_TAKEN,
  input  logic                         Branch_abs,
  input  logic                         Branch_rel,
  input  logic                         Call,
  input  logic                         Ret,
  input  logic [W-1:0]                 Target,
  input  logic [OW-1:0]                Offset,
  output logic [W-1:0]                 PC,
  output logic                         Halt,
  output logic                         Stack_err,
  output logic [$clog2(DEPTH+1)-1:0]   Depth
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]          pc_q, pc_d;
  logic                  halt_q, halt_d;
  logic                  err_q, err_d;
  logic [DW-1:0]         depth_q, depth_d;
  logic [W-1:0]          stack_q [DEPTH];
  logic                  push;
  logic [W-1:0]          pc_inc;
  logic signed [OW-1:0]  off_s;
  logic signed [W-1:0]   off_ext;
  logic [AW-1:0]         push_idx, top_idx;

  always_comb begin
    pc_inc   = pc_q + W'(1);
    off_s    = Offset;
    off_ext  = W'(off_s);
    push_idx = AW'(depth_q);
    top_idx  = AW'(depth_q - DW'(1));
    pc_d     = pc_q;
    halt_d   = halt_q;
    err_d    = err_q;
    depth_d  = depth_q;
    push     = 1'b0;
    if (halt_q) begin
      pc_d = pc_q;
    end else if (pc_q == W'(HALT_ADDR)) begin
      halt_d = 1'b1;
    end else if (Stall) begin
      pc_d = pc_q;
    end else if (Ret) begin
      if (depth_q != '0) begin
        pc_d    = stack_q[top_idx];
        depth_d = depth_q - DW'(1);
      end else begin
        err_d = 1'b1;
        pc_d  = pc_inc;
      end
    end else if (Call) begin
      if (depth_q < DW'(DEPTH)) begin
        push    = 1'b1;
        pc_d    = Target;
        depth_d = depth_q + DW'(1);
      end else begin
        err_d = 1'b1;
        pc_d  = pc_inc;
      end
    end else if (Branch_abs && B_TAKEN) begin
      pc_d = Target;
    end else if (Branch_rel && B_TAKEN) begin
      pc_d = pc_q + off_ext;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      pc_q    <= W'(RESET_ADDR);
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
      depth_q <= '0;
    end else begin
      pc_q    <= pc_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
      depth_q <= depth_d;
    end
  end

  // Stack storage is data only: never cleared, written on a successful push.
  always_ff @(posedge CLK) begin
    if (push && !Init) stack_q[push_idx] <= pc_inc;
  end

  assign PC        = pc_q;
  assign Halt      = halt_q;
  assign Stack_err = err_q;
  assign Depth     = depth_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: directed scenarios plus random stimulus against a queue-based model.
module tb_pc_seq;

  logic        CLK;
  logic        Init, Stall, B_TAKEN, Branch_abs, Branch_rel, Call, Ret;
  logic [15:0] Target;
  logic [7:0]  Offset;
  logic [15:0] PC;
  logic        Halt, Stack_err;
  logic [2:0]  Depth;

  int n_chk = 0;
  int n_err = 0;

  int m_pc;
  bit m_halt, m_err;
  int m_stk[$];

  pc_seq #(.W(16), .OW(8), .DEPTH(4), .RESET_ADDR(0), .HALT_ADDR(143)) u_dut (
    .CLK(CLK), .Init(Init), .Stall(Stall), .B_TAKEN(B_TAKEN),
    .Branch_abs(Branch_abs), .Branch_rel(Branch_rel), .Call(Call), .Ret(Ret),
    .Target(Target), .Offset(Offset), .PC(PC), .Halt(Halt),
    .Stack_err(Stack_err), .Depth(Depth)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    Init = 0; Stall = 0; B_TAKEN = 0; Branch_abs = 0; Branch_rel = 0;
    Call = 0; Ret = 0; Target = '0; Offset = '0;
  endtask

  // Reference behaviour taken straight from the rule list, first match wins.
  task automatic model_update();
    int off;
    off = int'($signed(Offset));
    if (Init) begin
      m_pc = 0; m_halt = 0; m_err = 0; m_stk.delete();
    end else if (m_halt) begin
    end else if (m_pc == 143) begin
      m_halt = 1;
    end else if (Stall) begin
    end else if (Ret) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_err = 1; m_pc = (m_pc + 1) % 65536; end
    end else if (Call) begin
      if (m_stk.size() < 4) begin
        m_stk.push_back((m_pc + 1) % 65536);
        m_pc = int'(Target);
      end else begin
        m_err = 1; m_pc = (m_pc + 1) % 65536;
      end
    end else if (Branch_abs && B_TAKEN) begin
      m_pc = int'(Target);
    end else if (Branch_rel && B_TAKEN) begin
      m_pc = (m_pc + off) & 32'hFFFF;
    end else begin
      m_pc = (m_pc + 1) % 65536;
    end
  endtask

  task automatic step(input string tag);
    @(posedge CLK);
    model_update();
    #1;
    chk({tag, ".pc"},    32'(PC),        32'(m_pc));
    chk({tag, ".halt"},  32'(Halt),      32'(m_halt));
    chk({tag, ".err"},   32'(Stack_err), 32'(m_err));
    chk({tag, ".depth"}, 32'(Depth),     32'(m_stk.size()));
  endtask

  task automatic do_init();
    idle(); Init = 1; step("init"); idle();
  endtask

  task automatic jump(input logic [15:0] t);
    idle(); Branch_abs = 1; B_TAKEN = 1; Target = t; step("jump"); idle();
  endtask

  initial begin
    idle();
    m_pc = 0; m_halt = 0; m_err = 0;

    // Reset and increment
    do_init();
    chk("rst.pc", 32'(PC), 0);
    chk("rst.halt", 32'(Halt), 0);
    chk("rst.err", 32'(Stack_err), 0);
    chk("rst.depth", 32'(Depth), 0);
    for (int i = 1; i <= 5; i++) begin
      step("inc");
      chk("inc.const", 32'(PC), 32'(i));
    end

    // Branches
    jump(16'd10);
    idle(); Branch_rel = 1; B_TAKEN = 1; Offset = 8'hFA; step("rel_neg");
    chk("rel_neg.const", 32'(PC), 4);
    idle(); Branch_abs = 1; B_TAKEN = 0; Target = 16'd77; step("abs_nt");
    chk("abs_nt.const", 32'(PC), 5);
    do_init();
    idle(); Branch_rel = 1; B_TAKEN = 1; Offset = 8'hFF; step("rel_wrap");
    chk("rel_wrap.const", 32'(PC), 32'hFFFF);
    idle(); step("inc_wrap");
    chk("inc_wrap.const", 32'(PC), 0);

    // Call/return nesting
    jump(16'd20);
    idle(); Call = 1; Target = 16'd100; step("call1");
    chk("call1.const", 32'(PC), 100);
    idle(); Call = 1; Target = 16'd200; step("call2");
    chk("call2.depth_c", 32'(Depth), 2);
    idle(); Ret = 1; step("ret1");
    chk("ret1.const", 32'(PC), 101);
    idle(); Ret = 1; step("ret2");
    chk("ret2.const", 32'(PC), 21);
    chk("ret2.depth_c", 32'(Depth), 0);

    // Stack overflow and underflow
    do_init();
    for (int i = 0; i < 5; i++) begin
      idle(); Call = 1; Target = 16'(1000 + 10 * i); step("call_ovf");
    end
    chk("ovf.pc_c", 32'(PC), 1031);
    chk("ovf.err_c", 32'(Stack_err), 1);
    chk("ovf.depth_c", 32'(Depth), 4);
    do_init();
    chk("init_clr.err", 32'(Stack_err), 0);
    idle(); Ret = 1; step("udf");
    chk("udf.err_c", 32'(Stack_err), 1);
    chk("udf.pc_c", 32'(PC), 1);

    // Stall and priority
    do_init();
    idle(); Call = 1; Target = 16'd50; step("call_s");
    for (int i = 0; i < 3; i++) begin
      idle(); Stall = 1; Call = 1; Target = 16'd300; step("stall_call");
    end
    chk("stall.pc_c", 32'(PC), 50);
    chk("stall.depth_c", 32'(Depth), 1);
    idle(); Ret = 1; Call = 1; Target = 16'd400; step("ret_call");
    chk("ret_call.pc_c", 32'(PC), 1);
    chk("ret_call.depth_c", 32'(Depth), 0);
    jump(16'd77);
    idle(); Stall = 1; Init = 1; step("stall_init");
    chk("stall_init.pc_c", 32'(PC), 0);

    // Halt: freezes even against stall and taken branches
    jump(16'd140);
    idle(); step("h141"); step("h142"); step("h143");
    chk("h143.halt_c", 32'(Halt), 0);
    idle(); Stall = 1; step("halt_set");
    chk("halt_set.c", 32'(Halt), 1);
    for (int i = 0; i < 10; i++) begin
      idle(); Branch_abs = 1; B_TAKEN = 1; Target = 16'd5; step("halted");
    end
    chk("halted.pc_c", 32'(PC), 143);
    do_init();
    chk("unhalt.c", 32'(Halt), 0);

    // Randomized stimulus
    for (int i = 0; i < 3000; i++) begin
      idle();
      Init       = ($urandom_range(0, 63) == 0);
      Stall      = ($urandom_range(0, 7) == 0);
      Ret        = ($urandom_range(0, 5) == 0);
      Call       = ($urandom_range(0, 5) == 0);
      Branch_abs = ($urandom_range(0, 3) == 0);
      Branch_rel = ($urandom_range(0, 3) == 0);
      B_TAKEN    = 1'($urandom);
      Target     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(130, 145)) : 16'($urandom);
      Offset     = 8'($urandom);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the basic processor's instruction-fetch stage. Replaces the fixed-width single-target PC with configurable width, a programmable halt address, taken-branch support in absolute and PC-relative forms, a call/return stack of configurable depth, and a fetch stall. It drives the instruction-memory address every cycle and reports halt and stack-fault status to the controller.

## Interface
- W, 16: PC width in bits; all PC arithmetic is modulo 2^W.
- OW, 8: width of the signed relative-branch offset.
- DEPTH, 4: return-stack entries, minimum 1.
- RESET_ADDR, 0: PC value loaded by Init.
- HALT_ADDR, 143: PC value that triggers halt.
- CLK  in  1  clock; all state changes on posedge only.
- Init  in  1  reset, synchronous, active-high.
- Stall  in  1  1 = hold PC and stack this cycle.
- B_TAKEN  in  1  branch condition from the ALU flags.
- Branch_abs  in  1  conditional absolute jump to Target.
- Branch_rel  in  1  conditional relative jump by Offset.
- Call  in  1  unconditional call to Target, pushes return address.
- Ret  in  1  unconditional return, pops return address.
- Target  in  W  absolute jump/call destination.
- Offset  in  OW  two's-complement relative offset.
- PC  out  W  current fetch address.
- Halt  out  1  sticky; 1 = PC frozen.
- Stack_err  out  1  sticky overflow/underflow flag.
- Depth  out  $clog2(DEPTH+1)  current stack occupancy.

## Operation
- Init at posedge: PC <= RESET_ADDR, Halt <= 0, Stack_err <= 0, Depth <= 0. Stack contents are not cleared. Init overrides every other input.
- Otherwise, the first matching rule below applies at each posedge:
  1. Halt == 1: hold all state until Init.
  2. PC == HALT_ADDR: Halt <= 1; PC is not changed. This check ignores Stall and every branch input.
  3. Stall: hold PC, stack and Depth.
  4. Ret: if Depth > 0, PC <= top entry and Depth decrements. If Depth == 0 (underflow), Stack_err <= 1 and PC <= PC+1.
  5. Call: if Depth < DEPTH, push PC+1 (mod 2^W), PC <= Target and Depth increments. If Depth == DEPTH (overflow), Stack_err <= 1, no push, PC <= PC+1.
  6. Branch_abs && B_TAKEN: PC <= Target.
  7. Branch_rel && B_TAKEN: PC <= PC + sign-extended Offset, modulo 2^W (wrap in both directions).
  8. Default: PC <= PC+1; 2^W−1 wraps to 0.
- Branch_abs or Branch_rel with B_TAKEN == 0 falls through to the default increment.
- When several control inputs are asserted together, the priority order above resolves them. The lower-priority inputs are ignored for that cycle.
- Stack_err does not stop execution and clears only on Init.
- Stack is LIFO; the entry at index Depth−1 is the top.

## Timing
- Single-cycle: each decision is taken from the current-cycle inputs and PC, and the result appears on PC after the same posedge. There is no internal pipelining.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset values: PC = RESET_ADDR, Halt = 0, Stack_err = 0, Depth = 0.
- Halt asserts on the first posedge at which PC == HALT_ADDR; PC keeps that value.
- Init asserted mid-call, mid-stall or while halted takes effect at the next posedge. Any pending Stack_err is discarded.
- A Call followed by a Ret on the next cycle restores the original PC+1. Round-trip latency is 2 cycles.

## Test plan
- Reset and increment: hold Init 1 cycle, then run 5 cycles -> PC 0,1,2,3,4,5. Halt and Stack_err stay 0.
- Halt: W=16, HALT_ADDR=143, start from RESET_ADDR 140 with no branches -> PC 140,141,142,143; Halt = 1 one posedge after PC reaches 143. PC stays 143 for 10 further cycles even with Branch_abs=B_TAKEN=1. Init then gives PC=RESET_ADDR and Halt=0.
- Branches: at PC=10, Branch_rel=1, B_TAKEN=1, Offset=8'hFA (−6) -> PC=4. At PC=4, Branch_abs=1, B_TAKEN=0 -> PC=5. At PC=0, Offset=−1 -> PC=16'hFFFF.
- Call/return nesting, DEPTH=4: at PC=20, Call with Target=100 -> PC=100, Depth=1. At PC=100, Call with Target=200 -> PC=200, Depth=2. Then Ret -> PC=101; Ret -> PC=21, Depth=0.
- Stack faults: five Calls with DEPTH=4 -> the fifth gives PC = old PC+1, Stack_err=1, Depth=4. After Init, a Ret with Depth=0 -> Stack_err=1, PC=1.
- Stall and priority: Stall=1 with Call=1 for 3 cycles -> PC and Depth unchanged. Ret=1 and Call=1 together at Depth=1 -> pop wins, Depth=0. Stall=1 with Init=1 -> PC=RESET_ADDR.
